// File: rtl/trans_pkg.sv
// Shared definitions for the transaction-layer control FSM: state encoding and bank defaults.
package trans_pkg;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam int NUM_FIFOS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 8;

endpackage

// File: rtl/prio_enc_low.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module prio_enc_low #(
    parameter int NUM_FIFOS    = 8,
    parameter int FIFO_ID_SIZE = $clog2(NUM_FIFOS)
) (
    input  logic [NUM_FIFOS-1:0]    req_i,
    output logic [FIFO_ID_SIZE-1:0] idx_o,
    output logic                    any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        // Scan downwards so the lowest set index is written last and wins.
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = FIFO_ID_SIZE'(i);
        end
    end

endmodule

// File: rtl/trans_ctrl_fsm.sv
// Transaction-layer control FSM: reset/init/idle/active sequencing with a sticky error state.
// Optional threshold-pair validation in INIT is enabled by defining TRANS_FSM_THRESH_CHECK_EN.
module trans_ctrl_fsm
    import trans_pkg::*;
#(
    parameter int NUM_FIFOS     = NUM_FIFOS_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int FIFO_PTR_SIZE = $clog2(FIFO_DEPTH),
    parameter int FIFO_ID_SIZE  = $clog2(NUM_FIFOS)
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     init,
    input  logic [FIFO_PTR_SIZE-1:0] almost_empty_threshold_input,
    input  logic [FIFO_PTR_SIZE-1:0] almost_full_threshold_input,
    input  logic [NUM_FIFOS-1:0]     FIFOs_empty,
    input  logic [NUM_FIFOS-1:0]     FIFOs_error,
    output logic [FIFO_PTR_SIZE-1:0] almost_empty_threshold,
    output logic [FIFO_PTR_SIZE-1:0] almost_full_threshold,
    output logic                     idle,
    output logic                     active,
    output logic                     error,
    output logic [FIFO_ID_SIZE-1:0]  error_fifo_id,
    output logic [2:0]               state,
    output logic                     cfg_invalid
);

    logic [2:0]               state_q, state_d;
    logic [FIFO_PTR_SIZE-1:0] ae_q, ae_d;
    logic [FIFO_PTR_SIZE-1:0] af_q, af_d;
    logic [FIFO_ID_SIZE-1:0]  err_id_q, err_id_d;
    logic [FIFO_ID_SIZE-1:0]  err_idx;
    logic                     err_any;
    logic                     cfg_ok;

    prio_enc_low #(
        .NUM_FIFOS    (NUM_FIFOS),
        .FIFO_ID_SIZE (FIFO_ID_SIZE)
    ) u_err_enc (
        .req_i (FIFOs_error),
        .idx_o (err_idx),
        .any_o (err_any)
    );

`ifdef TRANS_FSM_THRESH_CHECK_EN
    logic cfg_inv_q, cfg_inv_d;

    assign cfg_ok      = almost_empty_threshold_input < almost_full_threshold_input;
    assign cfg_inv_d   = (state_q == ST_INIT) && !cfg_ok;
    assign cfg_invalid = cfg_inv_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) cfg_inv_q <= 1'b0;
        else          cfg_inv_q <= cfg_inv_d;
    end
`else
    assign cfg_ok      = 1'b1;
    assign cfg_invalid = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        err_id_d = err_id_q;
        ae_d     = ae_q;
        af_d     = af_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (cfg_ok) begin
                    ae_d = almost_empty_threshold_input;
                    af_d = almost_full_threshold_input;
                end
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (err_any) begin
                    state_d  = ST_ERROR;
                    err_id_d = err_idx;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (!(&FIFOs_empty)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: if (init) state_d = ST_INIT;
            default:  state_d = ST_RESET;
        endcase
        // Every fresh entry into INIT starts with a clean fault record.
        if (state_d == ST_INIT && state_q != ST_INIT) err_id_d = '0;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_RESET;
            ae_q     <= '0;
            af_q     <= '0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            err_id_q <= err_id_d;
        end
    end

    assign state                  = state_q;
    assign idle                   = (state_q == ST_IDLE);
    assign active                 = (state_q == ST_ACTIVE);
    assign error                  = (state_q == ST_ERROR);
    assign error_fifo_id          = err_id_q;
    assign almost_empty_threshold = ae_q;
    assign almost_full_threshold  = af_q;

endmodule

// File: tb/tb_trans_ctrl_fsm.sv
// Directed self-checking bench for trans_ctrl_fsm (default 8 FIFOs, depth 8).
module tb_trans_ctrl_fsm;

    logic       clk;
    logic       reset_L;
    logic       init;
    logic [2:0] ae_in, af_in;
    logic [7:0] fifos_empty, fifos_error;
    logic [2:0] ae_out, af_out;
    logic       idle, active, error;
    logic [2:0] err_id;
    logic [2:0] state;
    logic       cfg_invalid;

    int total = 0;
    int bad   = 0;

    trans_ctrl_fsm dut (
        .clk                          (clk),
        .reset_L                      (reset_L),
        .init                         (init),
        .almost_empty_threshold_input (ae_in),
        .almost_full_threshold_input  (af_in),
        .FIFOs_empty                  (fifos_empty),
        .FIFOs_error                  (fifos_error),
        .almost_empty_threshold       (ae_out),
        .almost_full_threshold        (af_out),
        .idle                         (idle),
        .active                       (active),
        .error                        (error),
        .error_fifo_id                (err_id),
        .state                        (state),
        .cfg_invalid                  (cfg_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0; init = 1'b0; ae_in = 3'd0; af_in = 3'd0;
        fifos_empty = 8'hFF; fifos_error = 8'h00;
        tick(); tick();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if ({idle, active, error, cfg_invalid} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {idle, active, error, cfg_invalid}); end
        total++; if ({ae_out, af_out, err_id} !== 9'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {ae_out, af_out, err_id}); end
        init = 1'b1; ae_in = 3'd2; af_in = 3'd6;
        reset_L = 1'b1;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL release_init got=%0d exp=1", state); end
    endtask

    task automatic test_init();
        tick();
        total++; if ({ae_out, af_out} !== {3'd2, 3'd6}) begin bad++; $display("FAIL init_load got=%0d/%0d exp=2/6", ae_out, af_out); end
        init = 1'b0;
        tick();
        total++; if (idle !== 1'b1 || state !== 3'd2) begin bad++; $display("FAIL init_to_idle got idle=%b state=%0d exp idle=1 state=2", idle, state); end
        ae_in = 3'd1; af_in = 3'd7;
        tick();
        total++; if ({ae_out, af_out} !== {3'd2, 3'd6}) begin bad++; $display("FAIL thresh_hold got=%0d/%0d exp=2/6", ae_out, af_out); end
    endtask

    task automatic test_active_idle();
        fifos_empty = 8'hF7;
        tick();
        total++; if (active !== 1'b1 || idle !== 1'b0 || state !== 3'd3) begin bad++; $display("FAIL go_active got active=%b state=%0d exp active=1 state=3", active, state); end
        fifos_empty = 8'hFF;
        tick();
        total++; if (idle !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL back_idle got idle=%b active=%b exp 1/0", idle, active); end
        fifos_empty = 8'h7F;
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("FAIL active_msb got=%b exp=1", active); end
    endtask

    task automatic test_error();
        fifos_error = 8'b0010_0100;
        tick();
        total++; if (error !== 1'b1 || state !== 3'd4 || active !== 1'b0) begin bad++; $display("FAIL err_entry got error=%b state=%0d exp error=1 state=4", error, state); end
        total++; if (err_id !== 3'd2) begin bad++; $display("FAIL err_id got=%0d exp=2", err_id); end
        fifos_error = 8'h00; fifos_empty = 8'hFF;
        tick(); tick();
        total++; if (error !== 1'b1 || err_id !== 3'd2) begin bad++; $display("FAIL err_sticky got error=%b id=%0d exp 1/2", error, err_id); end
        init = 1'b1; ae_in = 3'd2; af_in = 3'd6;
        tick();
        total++; if (state !== 3'd1 || err_id !== 3'd0 || error !== 1'b0) begin bad++; $display("FAIL err_exit got state=%0d id=%0d exp state=1 id=0", state, err_id); end
        fifos_error = 8'h01;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL init_ignores_err got=%0d exp=1", state); end
        fifos_error = 8'h00; init = 1'b0;
        tick();
        init = 1'b1; fifos_error = 8'hC0;
        tick();
        total++; if (state !== 3'd4 || err_id !== 3'd6) begin bad++; $display("FAIL err_beats_init got state=%0d id=%0d exp state=4 id=6", state, err_id); end
        fifos_error = 8'h00;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL err_to_init got=%0d exp=1", state); end
    endtask

    task automatic test_cfg_check();
        ae_in = 3'd2; af_in = 3'd6;
        tick();
        total++; if ({ae_out, af_out} !== {3'd2, 3'd6} || cfg_invalid !== 1'b0) begin bad++; $display("FAIL cfg_valid got=%0d/%0d inv=%b exp=2/6 inv=0", ae_out, af_out, cfg_invalid); end
        ae_in = 3'd5; af_in = 3'd3;
        tick();
`ifdef TRANS_FSM_THRESH_CHECK_EN
        total++; if ({ae_out, af_out} !== {3'd2, 3'd6} || cfg_invalid !== 1'b1) begin bad++; $display("FAIL cfg_reject got=%0d/%0d inv=%b exp=2/6 inv=1", ae_out, af_out, cfg_invalid); end
`else
        total++; if ({ae_out, af_out} !== {3'd5, 3'd3} || cfg_invalid !== 1'b0) begin bad++; $display("FAIL cfg_load_any got=%0d/%0d inv=%b exp=5/3 inv=0", ae_out, af_out, cfg_invalid); end
`endif
        total++; if (state !== 3'd1) begin bad++; $display("FAIL cfg_state got=%0d exp=1", state); end
        ae_in = 3'd2; af_in = 3'd6; init = 1'b0;
        tick();
        total++; if ({ae_out, af_out} !== {3'd2, 3'd6} || cfg_invalid !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL cfg_final got=%0d/%0d inv=%b idle=%b exp=2/6 inv=0 idle=1", ae_out, af_out, cfg_invalid, idle); end
    endtask

    task automatic test_async_reset();
        fifos_empty = 8'hF0; fifos_error = 8'h00;
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("FAIL pre_reset_active got=%b exp=1", active); end
        #2;
        reset_L = 1'b0;
        #1;
        total++; if (state !== 3'd0 || active !== 1'b0) begin bad++; $display("FAIL async_state got state=%0d active=%b exp 0/0", state, active); end
        total++; if ({ae_out, af_out, err_id} !== 9'd0) begin bad++; $display("FAIL async_regs got=%h exp=0", {ae_out, af_out, err_id}); end
        tick();
        reset_L = 1'b1; init = 1'b0;
        tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rerelease got=%0d exp=1", state); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_active_idle();
        test_error();
        test_cfg_check();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog elapsed before completion");
        $fatal(1, "timeout");
    end

endmodule
